// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//                Holds the loader state encoding and the default frame-start
//                marker.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    // Default frame start marker
    localparam logic [7:0] C_LDR_SYNC_DEFAULT = 8'hA5;

    // Width of the word counter. It is wide enough for any legal image
    // (MAX_WORDS <= 64 fits in 7 bits with room for the terminal count).
    localparam int unsigned C_WORD_CNT_W = 7;

    // Loader states, 3-bit encoding
    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LEN  = 3'd1,
        LDR_DATA = 3'd2,
        LDR_CSUM = 3'd3,
        LDR_DONE = 3'd4,
        LDR_ERR  = 3'd5
    } ldr_state_t;

endpackage : imem_loader_pkg

`default_nettype wire

// File: rtl/ldr_word_packer.sv
// ============================================================================
//  Module      : ldr_word_packer
//  Description : Packs bytes into a 32-bit little-endian word, keeps the
//                running XOR checksum of all packed bytes, and flags the
//                byte that completes a word.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_clear         restart packing: byte index, word, checksum
//                i_byte_en       i_byte is consumed this cycle
//                i_byte          data byte
//                o_word          word including the byte currently offered
//                o_word_full     i_byte completes a word this cycle
//                o_csum          XOR of all bytes consumed since i_clear
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ldr_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full,
    output logic [7:0]  o_csum
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic [7:0]  r_csum;
    logic [31:0] w_word;

    // The completed word is presented combinationally so the top can register
    // it into the write port at the same edge that accepts the 4th byte.
    always_comb begin
        w_word                 = r_word;
        w_word[8*r_idx +: 8]   = i_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
            r_csum <= 8'd0;
        end else if (i_clear) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
            r_csum <= 8'd0;
        end else if (i_byte_en) begin
            r_idx  <= r_idx + 2'd1;
            r_word <= w_word;
            r_csum <= r_csum ^ i_byte;
        end
    end

    assign o_word      = w_word;
    assign o_word_full = i_byte_en && (r_idx == 2'd3);
    assign o_csum      = r_csum;

endmodule : ldr_word_packer

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a framed byte stream (SYNC, LEN, 4*LEN data bytes,
//                XOR checksum), writes each little-endian word into
//                instruction memory and holds the core in reset until a
//                complete image with a good checksum is loaded.
//  Ports       : clk, rst                 clock / async active-low reset
//                in_valid, in_data        byte stream in
//                in_ready                 byte accepted on valid & ready
//                imem_we/addr/wdata       single-cycle memory write port
//                cpu_hold                 core held in reset while 1
//                done                     image loaded, checksum good
//                error                    frame rejected (length/checksum)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_ADDR  = 8,
    parameter logic [7:0]  SYNC_BYTE = C_LDR_SYNC_DEFAULT,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                imem_we,
    output logic [MEM_ADDR-1:0] imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    ldr_state_t r_state;
    ldr_state_t w_state_nxt;

    logic [C_WORD_CNT_W-1:0] r_word_cnt;
    logic [C_WORD_CNT_W-1:0] r_len;
    logic [C_WORD_CNT_W-1:0] w_cnt_inc;
    logic                    r_we;
    logic [MEM_ADDR-1:0]     r_addr;
    logic [31:0]             r_wdata;

    logic        w_acc;
    logic        w_sync;
    logic        w_len_bad;
    logic        w_clear;
    logic        w_byte_en;
    logic [31:0] w_word;
    logic        w_word_full;
    logic [7:0]  w_csum;

    // The write slot steals one cycle of the byte interface; a byte offered
    // then is simply held by the source until the next cycle.
    assign w_acc     = in_valid && !r_we;
    assign w_sync    = (in_data == SYNC_BYTE);
    assign w_len_bad = (in_data == 8'd0) || (32'(in_data) > MAX_WORDS);
    assign w_cnt_inc = r_word_cnt + 1'b1;

    ldr_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst),
        .i_clear     (w_clear),
        .i_byte_en   (w_byte_en),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_full (w_word_full),
        .o_csum      (w_csum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LDR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_byte_en   = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            LDR_IDLE: begin
                if (w_acc && w_sync) w_state_nxt = LDR_LEN;
            end
            LDR_LEN: begin
                if (w_acc) begin
                    if (w_len_bad) begin
                        w_state_nxt = LDR_ERR;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                if (w_acc) begin
                    w_byte_en = 1'b1;
                    if (w_word_full && (w_cnt_inc == r_len)) w_state_nxt = LDR_CSUM;
                end
            end
            LDR_CSUM: begin
                if (w_acc) w_state_nxt = (in_data == w_csum) ? LDR_DONE : LDR_ERR;
            end
            LDR_DONE: begin
                done = 1'b1;
                if (w_acc && w_sync) w_state_nxt = LDR_LEN;
            end
            LDR_ERR: begin
                error = 1'b1;
                if (w_acc && w_sync) w_state_nxt = LDR_LEN;
            end
            default: begin
                w_state_nxt = LDR_IDLE;
            end
        endcase
    end

    // Write port register: the word completed at edge N is written in cycle
    // N+1. Address and data keep their last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
            r_len      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            r_we <= w_word_full;
            if (w_word_full) begin
                r_addr     <= {r_word_cnt[MEM_ADDR-3:0], 2'b00};
                r_wdata    <= w_word;
                r_word_cnt <= w_cnt_inc;
            end
            if (w_clear) begin
                r_word_cnt <= '0;
                r_len      <= in_data[C_WORD_CNT_W-1:0];
            end
        end
    end

    assign in_ready   = !r_we;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = !done;

endmodule : imem_loader

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Table of frames with
//                expected writes and status, plus hand-written sequences for
//                async reset mid-frame and reload from DONE.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int hs_bad = 0;

    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor and handshake watcher
    always @(negedge clk) begin
        if (rst) begin
            if (imem_we === 1'b1) begin
                wq_addr.push_back(imem_addr);
                wq_data.push_back(imem_wdata);
            end
            if (in_ready !== ~imem_we) hs_bad++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one byte (in_valid stays high afterwards); returns at the
    // negedge following the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    typedef struct {
        int          start;
        int          n;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    // XOR of 11..88 is 0x88; XOR of DE AD BE EF is 0x22; XOR of 01..04 is 0x04.
    logic [7:0] bytes [0:29] = '{
        8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88,
        8'h5A,
        8'hA5, 8'h00,
        8'hA5, 8'h41,
        8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00,
        8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04
    };

    vec_t vecs [0:4];

    initial begin
        // The leading 0x5A after the first frame is a stray byte discarded in DONE.
        vecs[0] = '{0,  12, 2, 32'h44332211, 32'h88776655, 1'b1, 1'b0};
        vecs[1] = '{12, 2,  0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[2] = '{14, 2,  0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[3] = '{16, 7,  1, 32'hEFBEADDE, 32'h0,        1'b0, 1'b1};
        vecs[4] = '{23, 7,  1, 32'h04030201, 32'h0,        1'b1, 1'b0};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_we",       {31'd0, imem_we},  32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done_err", {30'd0, done, error}, 32'd0);
        check("rst_addr_data", {24'd0, imem_addr} | imem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            wq_addr.delete();
            wq_data.delete();
            for (int k = 0; k < vecs[i].n; k++) send(bytes[vecs[i].start + k]);
            idle(3);
            check($sformatf("v%0d_nwrites", i), wq_addr.size(), vecs[i].nw);
            if (vecs[i].nw >= 1 && wq_addr.size() >= 1) begin
                check($sformatf("v%0d_w0_addr", i), {24'd0, wq_addr[0]}, 32'h0);
                check($sformatf("v%0d_w0_data", i), wq_data[0], vecs[i].w0);
            end
            if (vecs[i].nw >= 2 && wq_addr.size() >= 2) begin
                check($sformatf("v%0d_w1_addr", i), {24'd0, wq_addr[1]}, 32'h4);
                check($sformatf("v%0d_w1_data", i), wq_data[1], vecs[i].w1);
            end
            if (vecs[i].nw >= 1) begin
                // Write port holds the last write between strobes
                check($sformatf("v%0d_hold_addr", i), {24'd0, imem_addr}, 32'(4 * (vecs[i].nw - 1)));
                check($sformatf("v%0d_hold_data", i), imem_wdata,
                      (vecs[i].nw == 2) ? vecs[i].w1 : vecs[i].w0);
            end
            check($sformatf("v%0d_done", i),     {31'd0, done},     {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d_error", i),    {31'd0, error},    {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_cpu_hold", i), {31'd0, cpu_hold}, {31'd0, ~vecs[i].exp_done});
        end

        // Async reset while the first word of a frame is being written
        wq_addr.delete();
        wq_data.delete();
        for (int k = 0; k < 6; k++) send(bytes[k]);
        check("mid_we_before_rst", {31'd0, imem_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_we",       {31'd0, imem_we},  32'd0);
        check("mid_rst_ready",    {31'd0, in_ready}, 32'd1);
        check("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("mid_rst_done_err", {30'd0, done, error}, 32'd0);
        check("mid_rst_addr",     {24'd0, imem_addr}, 32'd0);
        check("mid_rst_wdata",    imem_wdata, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        wq_addr.delete();
        wq_data.delete();
        for (int k = 0; k < 11; k++) send(bytes[k]);
        idle(3);
        check("post_rst_nwrites", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            check("post_rst_w0", {wq_addr[0], wq_data[0][23:0]}, {8'h00, 24'h332211});
            check("post_rst_w1", {wq_addr[1], wq_data[1][23:0]}, {8'h04, 24'h776655});
        end
        check("post_rst_done", {31'd0, done}, 32'd1);

        // Reload from DONE with LEN=1
        wq_addr.delete();
        wq_data.delete();
        send(8'hA5);
        send(8'h01);
        check("reload_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("reload_done_low", {31'd0, done},     32'd0);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        send(8'h00);
        idle(3);
        check("reload_nwrites", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            check("reload_addr", {24'd0, wq_addr[0]}, 32'h0);
            check("reload_data", wq_data[0], 32'hDDCCBBAA);
        end
        check("reload_done",  {31'd0, done},     32'd1);
        check("reload_hold",  {31'd0, cpu_hold}, 32'd0);
        check("reload_error", {31'd0, error},    32'd0);

        check("handshake_ready_vs_we", hs_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_loader

`default_nettype wire
